// File: rtl/mem_access_ctrl.sv
// CPU-side load/store controller for a single-ported word memory: handles
// sub-word loads with extension, read-modify-write sub-word stores and misalignment.
module mem_access_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        AdEL,
  output logic        AdES,
  output logic [31:0] MAddr,
  output logic [31:0] MWData,
  output logic        MemWr,
  input  logic [31:0] MRData
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LW  = 3'b000, OP_LH = 3'b001, OP_LHU = 3'b010, OP_LB = 3'b011,
    OP_LBU = 3'b100, OP_SW = 3'b101, OP_SH  = 3'b110, OP_SB = 3'b111
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         word_q;
  logic [31:0]         rdata_q;
  logic                mis_q;
  logic                req_mis;

  // Upper address bits wrap within the memory and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:MEM_AW+2];

  function automatic logic is_load(input op_t op);
    return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
  endfunction

  function automatic logic misaligned(input op_t op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:          return a != 2'b00;
      OP_LH, OP_LHU, OP_SH:  return a[0];
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input op_t op, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  assign req_mis = misaligned(op_t'(Op), Addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Req) begin
          if (req_mis)                 state_d = DONE;
          else if (op_t'(Op) == OP_SW) state_d = WR;
          else                         state_d = RD;
        end
      end
      RD:      state_d = is_load(op_q) ? DONE : WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (Req) begin
            op_q    <= op_t'(Op);
            addr_q  <= Addr[MEM_AW+1:0];
            wdata_q <= WData;
            mis_q   <= req_mis;
            if (req_mis) rdata_q <= '0;
          end
        end
        RD: begin
          word_q <= MRData;
          if (is_load(op_q)) rdata_q <= load_ext(op_q, MRData, addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  assign Busy  = (state_q != IDLE);
  assign Done  = (state_q == DONE);
  assign MemWr = (state_q == WR);
  assign RData = rdata_q;
  assign AdEL  = Done && mis_q && is_load(op_q);
  assign AdES  = Done && mis_q && !is_load(op_q);
  assign MAddr = ((state_q == RD) || (state_q == WR)) ?
                 {{(30-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2], 2'b00} : '0;

  // Sub-word stores merge into the word captured during RD.
  always_comb begin
    MWData = '0;
    if (state_q == WR) begin
      MWData = word_q;
      case (op_q)
        OP_SW: MWData = wdata_q;
        OP_SH: begin
          if (addr_q[1]) MWData[31:16] = wdata_q[15:0];
          else           MWData[15:0]  = wdata_q[15:0];
        end
        OP_SB:   MWData[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: drivers queue expected completions and
// memory writes; negedge monitors pop and compare them against the DUT.
module tb_mem_access_ctrl;
  localparam int MEM_AW = 10;
  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Req = 1'b0;
  logic [2:0]  Op = '0;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic        Busy, Done, AdEL, AdES, MemWr;
  logic [31:0] RData, MAddr, MWData, MRData;

  logic [31:0] mem [0:(1<<MEM_AW)-1];
  bit          loaded = 1'b0;

  typedef struct { logic [31:0] rdata; logic adel; logic ades; int lat; int acc; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  exp_t sb[$];
  wr_t  wq[$];
  exp_t e;
  wr_t  w;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a1, a2;

  mem_access_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Op(Op), .Addr(Addr), .WData(WData),
    .Busy(Busy), .Done(Done), .RData(RData), .AdEL(AdEL), .AdES(AdES),
    .MAddr(MAddr), .MWData(MWData), .MemWr(MemWr), .MRData(MRData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign MRData = mem[MAddr[MEM_AW+1:2]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int unsigned i = 0; i < (1<<MEM_AW); i++) mem[i] = '0;
      mem[1]  = 32'h5566_7788;
      mem[4]  = 32'h8081_7F22;
      mem[8]  = 32'h1122_3344;
      mem[12] = 32'hBEEF_0000;
      mem[16] = 32'hCAFE_F00D;
      loaded  = 1'b1;
    end else if (MemWr) begin
      mem[MAddr[MEM_AW+1:2]] = MWData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (Done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("rdata", RData, e.rdata);
          chk("adel", {31'b0, AdEL}, {31'b0, e.adel});
          chk("ades", {31'b0, AdES}, {31'b0, e.ades});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
      if (MemWr) begin
        if (wq.size() == 0) chk("unexpected_memwr", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("maddr", MAddr, w.addr);
          chk("mwdata", MWData, w.data);
        end
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic eadel, input logic eades,
                       input int lat, input bit wr, input logic [31:0] ew);
    @(negedge clk);
    chk("idle_busy", {31'b0, Busy}, 32'd0);
    Op = op; Addr = a; WData = wd; Req = 1'b1;
    sb.push_back('{er, eadel, eades, lat, cyc + 1});
    if (wr) wq.push_back('{{20'b0, a[11:2], 2'b00}, ew});
    @(posedge clk);
    #1 Req = 1'b0;
    wait_done();
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_memwr", {31'b0, MemWr}, 32'd0);
    chk("rst_rdata", RData, 32'd0);
    chk("rst_maddr", MAddr, 32'd0);
    chk("rst_mwdata", MWData, 32'd0);
    chk("rst_adel_ades", {30'b0, AdEL, AdES}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(LB,  32'h0000_0012, 32'h0,         32'hFFFF_FF81, 0, 0, 2, 0, 32'h0);
    issue(LBU, 32'h0000_0013, 32'h0,         32'h0000_0080, 0, 0, 2, 0, 32'h0);
    issue(LW,  32'h0000_0010, 32'h0,         32'h8081_7F22, 0, 0, 2, 0, 32'h0);
    issue(SB,  32'h0000_0021, 32'hDEAD_BEAB, 32'h8081_7F22, 0, 0, 3, 1, 32'h1122_AB44);
    issue(LHU, 32'h0000_0020, 32'h0,         32'h0000_AB44, 0, 0, 2, 0, 32'h0);
    issue(SH,  32'h0000_0022, 32'h1234_5678, 32'h0000_AB44, 0, 0, 3, 1, 32'h5678_AB44);
    issue(LW,  32'h0000_0020, 32'h0,         32'h5678_AB44, 0, 0, 2, 0, 32'h0);
    issue(LHU, 32'h0000_0032, 32'h0,         32'h0000_BEEF, 0, 0, 2, 0, 32'h0);
    issue(LH,  32'h0000_0032, 32'h0,         32'hFFFF_BEEF, 0, 0, 2, 0, 32'h0);
    issue(SW,  32'h0000_0006, 32'h1111_2222, 32'h0,         0, 1, 1, 0, 32'h0);
    chk("mis_sw_mem", mem[1], 32'h5566_7788);
    issue(LBU, 32'h0000_0023, 32'h0,         32'h0000_0056, 0, 0, 2, 0, 32'h0);
    issue(LH,  32'h0000_0003, 32'h0,         32'h0,         1, 0, 1, 0, 32'h0);
    issue(LBU, 32'h0000_0013, 32'h0,         32'h0000_0080, 0, 0, 2, 0, 32'h0);
    issue(LW,  32'h0000_0011, 32'h0,         32'h0,         1, 0, 1, 0, 32'h0);
    issue(SW,  32'h8000_0FFC, 32'hA5A5_5A5A, 32'h0,         0, 0, 2, 1, 32'hA5A5_5A5A);
    issue(LW,  32'h0000_0FFC, 32'h0,         32'hA5A5_5A5A, 0, 0, 2, 0, 32'h0);
    issue(LW,  32'hFFFF_F010, 32'h0,         32'h8081_7F22, 0, 0, 2, 0, 32'h0);
    issue(SH,  32'h0000_0041, 32'h0000_9999, 32'h0,         0, 1, 1, 0, 32'h0);
    chk("mis_sh_mem", mem[16], 32'hCAFE_F00D);

    // Abort a read-modify-write while it sits in RD.
    @(negedge clk);
    Op = SH; Addr = 32'h0000_0040; WData = 32'h0000_7777; Req = 1'b1;
    @(posedge clk);
    #1 Req = 1'b0;
    @(negedge clk);
    chk("rmw_busy_before", {31'b0, Busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_memwr", {31'b0, MemWr}, 32'd0);
    chk("abort_maddr", MAddr, 32'd0);
    chk("abort_rdata", RData, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("abort_mem", mem[16], 32'hCAFE_F00D);
    issue(SW,  32'h0000_0040, 32'h0BAD_BEEF, 32'h0,         0, 0, 2, 1, 32'h0BAD_BEEF);
    chk("sw_after_reset_mem", mem[16], 32'h0BAD_BEEF);

    // Back-to-back with Req held high across sw then lw.
    @(negedge clk);
    Op = SW; Addr = 32'h0000_0050; WData = 32'h1357_9BDF; Req = 1'b1;
    a1 = cyc + 1;
    sb.push_back('{32'h0, 1'b0, 1'b0, 2, a1});
    wq.push_back('{32'h0000_0050, 32'h1357_9BDF});
    @(posedge clk);
    #1 Op = LW;
    a2 = -1;
    for (int i = 0; i < 10 && a2 < 0; i++) begin
      @(negedge clk);
      if (!Busy) begin
        a2 = cyc + 1;
        sb.push_back('{32'h1357_9BDF, 1'b0, 1'b0, 2, a2});
      end
    end
    chk("b2b_accept", 32'(a2), 32'(a1 + 3));
    @(posedge clk);
    #1 Req = 1'b0;
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
